// File: rtl/key_event_dispatch.sv
// Key event dispatcher: queues decoded PS/2 key events and routes them in order to
// port A (non-arrow) or port B (arrow). Define KEY_REPEAT_FILTER_EN to drop auto-repeat makes.
module key_event_dispatch #(
    parameter int DEPTH_LOG2 = 3
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [9:0]            kv_data,
    input  logic                  kv_valid,
    output logic [9:0]            a_data,
    output logic                  a_valid,
    input  logic                  a_ready,
    output logic [9:0]            b_data,
    output logic                  b_valid,
    input  logic                  b_ready,
    output logic [DEPTH_LOG2:0]   count,
    output logic                  ovf,
    input  logic                  ovf_clr
);

    localparam int DEPTH = 1 << DEPTH_LOG2;
    localparam logic [DEPTH_LOG2:0] FULL_COUNT = (DEPTH_LOG2 + 1)'(DEPTH);

    logic [9:0]            mem [DEPTH];
    logic [DEPTH_LOG2-1:0] wr_ptr_reg;
    logic [DEPTH_LOG2-1:0] rd_ptr_reg;
    logic [DEPTH_LOG2:0]   count_reg;
    logic [DEPTH_LOG2:0]   count_next;
    logic                  ovf_reg;

    logic [9:0] head;
    logic       not_empty;
    logic       full;
    logic       discard;
    logic       push_req;
    logic       push;
    logic       pop;
    logic       overflow;

    assign head      = mem[rd_ptr_reg];
    assign not_empty = (count_reg != '0);
    assign full      = (count_reg == FULL_COUNT);

    // Only the port selected by the head's arrow bit may pop; the other ready is ignored.
    assign a_valid = not_empty & ~head[8];
    assign b_valid = not_empty &  head[8];
    assign a_data  = head;
    assign b_data  = head;
    assign pop     = (a_valid & a_ready) | (b_valid & b_ready);

    assign push_req = kv_valid & ~discard;
    assign push     = push_req & (~full | pop);
    assign overflow = push_req & full & ~pop;

`ifdef KEY_REPEAT_FILTER_EN
    logic [8:0] last_key_reg;
    logic       last_valid_reg;
    logic       key_match;

    assign key_match = last_valid_reg & (kv_data[8:0] == last_key_reg);
    assign discard   = kv_valid & ~kv_data[9] & key_match;

    // Only makes that actually enter the queue become the repeat reference.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            last_key_reg   <= '0;
            last_valid_reg <= 1'b0;
        end else if (push & ~kv_data[9]) begin
            last_key_reg   <= kv_data[8:0];
            last_valid_reg <= 1'b1;
        end else if (kv_valid & kv_data[9] & key_match) begin
            last_valid_reg <= 1'b0;
        end
    end
`else
    assign discard = 1'b0;
`endif

    always_comb begin
        count_next = count_reg;
        case ({push, pop})
            2'b10:   count_next = count_reg + 1'b1;
            2'b01:   count_next = count_reg - 1'b1;
            default: count_next = count_reg;
        endcase
    end

    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr_reg] <= kv_data;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wr_ptr_reg <= '0;
            rd_ptr_reg <= '0;
            count_reg  <= '0;
            ovf_reg    <= 1'b0;
        end else begin
            if (push) begin
                wr_ptr_reg <= wr_ptr_reg + 1'b1;
            end
            if (pop) begin
                rd_ptr_reg <= rd_ptr_reg + 1'b1;
            end
            count_reg <= count_next;
            // A new overflow outranks a clear request in the same cycle.
            if (overflow) begin
                ovf_reg <= 1'b1;
            end else if (ovf_clr) begin
                ovf_reg <= 1'b0;
            end
        end
    end

    assign count = count_reg;
    assign ovf   = ovf_reg;

endmodule

// File: tb/tb_key_event_dispatch.sv
// Directed self-checking bench for key_event_dispatch; expectations follow the
// KEY_REPEAT_FILTER_EN setting of the build.
module tb_key_event_dispatch;

    logic       clk;
    logic       rst;
    logic [9:0] kv_data;
    logic       kv_valid;
    logic [9:0] a_data;
    logic       a_valid;
    logic       a_ready;
    logic [9:0] b_data;
    logic       b_valid;
    logic       b_ready;
    logic [3:0] count;
    logic       ovf;
    logic       ovf_clr;

    int vectors;
    int miscompares;
    logic [9:0] got[$];

    key_event_dispatch #(.DEPTH_LOG2(3)) dut (
        .clk      (clk),
        .rst      (rst),
        .kv_data  (kv_data),
        .kv_valid (kv_valid),
        .a_data   (a_data),
        .a_valid  (a_valid),
        .a_ready  (a_ready),
        .b_data   (b_data),
        .b_valid  (b_valid),
        .b_ready  (b_ready),
        .count    (count),
        .ovf      (ovf),
        .ovf_clr  (ovf_clr)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic push(input logic [9:0] d);
        kv_data  = d;
        kv_valid = 1'b1;
        tick();
        kv_valid = 1'b0;
    endtask

    // Accept everything until the queue empties or the cycle budget runs out.
    task automatic drain(input int max_cycles);
        got.delete();
        a_ready  = 1'b1;
        b_ready  = 1'b1;
        kv_valid = 1'b0;
        for (int i = 0; i < max_cycles; i++) begin
            if (count == 4'd0) break;
            if (a_valid) got.push_back(a_data);
            else if (b_valid) got.push_back(b_data);
            tick();
        end
    endtask

    task automatic check_seq(input string name, input logic [9:0] exp_q[$]);
        vectors++;
        if (got.size() != exp_q.size()) begin
            miscompares++;
            $display("FAIL %s length: got %0d expected %0d", name, got.size(), exp_q.size());
        end else begin
            for (int i = 0; i < exp_q.size(); i++) begin
                vectors++;
                if (got[i] !== exp_q[i]) begin
                    miscompares++;
                    $display("FAIL %s item %0d: got %h expected %h", name, i, got[i], exp_q[i]);
                end
            end
        end
        vectors++;
        if (count !== 4'd0) begin
            miscompares++;
            $display("FAIL %s drained count: got %0d expected 0", name, count);
        end
    endtask

    task automatic test_reset();
        vectors++;
        if (count !== 4'd0) begin miscompares++; $display("FAIL reset count: got %0d expected 0", count); end
        vectors++;
        if (a_valid !== 1'b0 || b_valid !== 1'b0) begin
            miscompares++; $display("FAIL reset valids: got a=%b b=%b expected 0 0", a_valid, b_valid);
        end
        vectors++;
        if (ovf !== 1'b0) begin miscompares++; $display("FAIL reset ovf: got %b expected 0", ovf); end
        $display("reset: count=%0d a_valid=%b b_valid=%b ovf=%b", count, a_valid, b_valid, ovf);
    endtask

    task automatic test_blocking();
        a_ready = 1'b1;
        b_ready = 1'b0;
        push(10'h175);
        push(10'h01C);
        repeat (10) tick();
        vectors++;
        if (b_valid !== 1'b1 || b_data !== 10'h175) begin
            miscompares++; $display("FAIL block head: got b_valid=%b b_data=%h expected 1 175", b_valid, b_data);
        end
        vectors++;
        if (a_valid !== 1'b0) begin miscompares++; $display("FAIL block a_valid: got %b expected 0", a_valid); end
        vectors++;
        if (count !== 4'd2) begin miscompares++; $display("FAIL block count: got %0d expected 2", count); end
        drain(20);
        check_seq("block order", '{10'h175, 10'h01C});
        $display("blocking: delivered %0d events", got.size());
    endtask

    task automatic test_route();
        a_ready = 1'b1;
        b_ready = 1'b1;
        kv_data = 10'h01D; kv_valid = 1'b1;
        tick();
        vectors++;
        if (a_valid !== 1'b1 || b_valid !== 1'b0 || a_data !== 10'h01D) begin
            miscompares++; $display("FAIL route A: got a_valid=%b b_valid=%b a_data=%h expected 1 0 01D", a_valid, b_valid, a_data);
        end
        kv_data = 10'h175;
        tick();
        kv_valid = 1'b0;
        vectors++;
        if (b_valid !== 1'b1 || a_valid !== 1'b0 || b_data !== 10'h175) begin
            miscompares++; $display("FAIL route B: got b_valid=%b a_valid=%b b_data=%h expected 1 0 175", b_valid, a_valid, b_data);
        end
        vectors++;
        if (count !== 4'd1) begin miscompares++; $display("FAIL route push+pop count: got %0d expected 1", count); end
        tick();
        vectors++;
        if (count !== 4'd0 || a_valid !== 1'b0 || b_valid !== 1'b0) begin
            miscompares++; $display("FAIL route empty: got count=%0d a=%b b=%b expected 0 0 0", count, a_valid, b_valid);
        end
        $display("route: 01D on A then 175 on B, count=%0d", count);
    endtask

    task automatic test_overflow();
        logic [9:0] exp_q[$];
        a_ready = 1'b0;
        b_ready = 1'b0;
        for (int i = 1; i <= 8; i++) begin
            push(10'(i));
            exp_q.push_back(10'(i));
        end
        vectors++;
        if (count !== 4'd8 || ovf !== 1'b0) begin
            miscompares++; $display("FAIL fill: got count=%0d ovf=%b expected 8 0", count, ovf);
        end
        push(10'h009);
        vectors++;
        if (count !== 4'd8 || ovf !== 1'b1) begin
            miscompares++; $display("FAIL overflow: got count=%0d ovf=%b expected 8 1", count, ovf);
        end
        ovf_clr = 1'b1;
        push(10'h00A);
        vectors++;
        if (ovf !== 1'b1) begin miscompares++; $display("FAIL ovf set-wins: got %b expected 1", ovf); end
        tick();
        ovf_clr = 1'b0;
        vectors++;
        if (ovf !== 1'b0) begin miscompares++; $display("FAIL ovf_clr: got %b expected 0", ovf); end
        drain(20);
        check_seq("overflow drain", exp_q);
        $display("overflow: drained %0d events, ovf=%b", got.size(), ovf);
    endtask

    task automatic test_full_push_pop();
        logic [9:0] exp_q[$];
        a_ready = 1'b0;
        b_ready = 1'b0;
        for (int i = 1; i <= 8; i++) begin
            push(10'h010 + 10'(i));
            if (i > 1) exp_q.push_back(10'h010 + 10'(i));
        end
        exp_q.push_back(10'h023);
        a_ready = 1'b1;
        push(10'h023);
        vectors++;
        if (count !== 4'd8 || ovf !== 1'b0) begin
            miscompares++; $display("FAIL full push+pop: got count=%0d ovf=%b expected 8 0", count, ovf);
        end
        vectors++;
        if (a_valid !== 1'b1 || a_data !== 10'h012) begin
            miscompares++; $display("FAIL full next head: got a_valid=%b a_data=%h expected 1 012", a_valid, a_data);
        end
        drain(20);
        check_seq("full drain", exp_q);
        $display("full push+pop: drained %0d events, last=%h", got.size(), got.size() > 0 ? got[got.size()-1] : 10'h0);
    endtask

    task automatic test_filter();
        logic [9:0] exp_q[$];
        logic [3:0] exp_count;
`ifdef KEY_REPEAT_FILTER_EN
        exp_q = '{10'h01D, 10'h21D, 10'h01D};
        exp_count = 4'd3;
`else
        exp_q = '{10'h01D, 10'h01D, 10'h01D, 10'h21D, 10'h01D};
        exp_count = 4'd5;
`endif
        a_ready = 1'b0;
        b_ready = 1'b0;
        push(10'h01D);
        push(10'h01D);
        push(10'h01D);
        push(10'h21D);
        push(10'h01D);
        vectors++;
        if (count !== exp_count || ovf !== 1'b0) begin
            miscompares++; $display("FAIL filter count: got count=%0d ovf=%b expected %0d 0", count, ovf, exp_count);
        end
        drain(20);
        check_seq("filter drain", exp_q);
        $display("filter: delivered %0d events", got.size());
    endtask

    task automatic test_reset_mid();
        a_ready = 1'b0;
        b_ready = 1'b0;
        push(10'h031);
        push(10'h132);
        push(10'h033);
        vectors++;
        if (count !== 4'd3) begin miscompares++; $display("FAIL pre-reset count: got %0d expected 3", count); end
        rst = 1'b0;
        #2;
        vectors++;
        if (count !== 4'd0 || a_valid !== 1'b0 || b_valid !== 1'b0 || ovf !== 1'b0) begin
            miscompares++; $display("FAIL async reset: got count=%0d a=%b b=%b ovf=%b expected 0 0 0 0", count, a_valid, b_valid, ovf);
        end
        tick();
        rst = 1'b1;
        push(10'h044);
        vectors++;
        if (a_valid !== 1'b1 || a_data !== 10'h044 || count !== 4'd1) begin
            miscompares++; $display("FAIL post-reset push: got a_valid=%b a_data=%h count=%0d expected 1 044 1", a_valid, a_data, count);
        end
        drain(20);
        check_seq("post-reset drain", '{10'h044});
        $display("reset mid-transfer: queue flushed, next event %h delivered", 10'h044);
    endtask

    initial begin
        vectors     = 0;
        miscompares = 0;
        rst      = 1'b0;
        kv_data  = '0;
        kv_valid = 1'b0;
        a_ready  = 1'b0;
        b_ready  = 1'b0;
        ovf_clr  = 1'b0;
        repeat (2) tick();
        test_reset();
        rst = 1'b1;
        tick();
        test_blocking();
        test_route();
        test_overflow();
        test_full_push_pop();
        test_filter();
        test_reset_mid();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/key_event_dispatch.md
KEY_EVENT_DISPATCH -- requirements
Module: key_event_dispatch

Interface
REQ-001 Parameter DEPTH_LOG2, default 3: FIFO depth is 2**DEPTH_LOG2 entries (8 at default).
REQ-002 clk  input  1  system clock; all state updates on its rising edge.
REQ-003 rst  input  1  reset, asynchronous, active-low.
REQ-004 kv_data  input  10  decoded key event {break, arrow, scancode[7:0]}, as produced by the PS/2 keyboard decoder.
REQ-005 kv_valid  input  1  one-cycle strobe; kv_data is valid in this cycle.
REQ-006 a_data  output  10  event for port A (non-arrow keys).
REQ-007 a_valid  output  1  port A event available.
REQ-008 a_ready  input  1  port A consumer accepts.
REQ-009 b_data  output  10  event for port B (arrow keys).
REQ-010 b_valid  output  1  port B event available.
REQ-011 b_ready  input  1  port B consumer accepts.
REQ-012 count  output  DEPTH_LOG2+1  current FIFO occupancy, 0..2**DEPTH_LOG2.
REQ-013 ovf  output  1  sticky overflow flag.
REQ-014 ovf_clr  input  1  synchronous clear of ovf.

Function
REQ-015 The event SHALL be enqueued when kv_valid=1, the FIFO is not full, and the repeat filter does not discard it (REQ-026).
REQ-016 When kv_valid=1 and the FIFO is full with no pop in the same cycle, the event SHALL be dropped and ovf set to 1.
REQ-017 When the FIFO is full and a pop occurs in the same cycle as kv_valid, the push SHALL be accepted and count SHALL be unchanged.
REQ-018 Head routing: head[8]=1 -> port B; head[8]=0 -> port A; a_valid and b_valid SHALL never be 1 simultaneously.
REQ-019 a_valid = (count!=0 and head[8]=0); b_valid = (count!=0 and head[8]=1); both are registered-state-derived, no combinational path from kv_valid.
REQ-020 The head SHALL be popped on (a_valid and a_ready) or (b_valid and b_ready); the ready of the non-selected port SHALL be ignored.
REQ-021 Strict in-order delivery: a head blocked on its port SHALL block all later events, including those for the other port.
REQ-022 a_data/b_data SHALL carry the head entry while their valid is 1 and SHALL hold it stable until popped; when their valid is 0 the value is don't-care (driven as head).
REQ-023 Latency: an event pushed in cycle N SHALL appear on its port valid in cycle N+1 when the FIFO was empty.
REQ-024 count SHALL increment on push only, decrement on pop only, and stay unchanged on push+pop or on neither.
REQ-025 Pointers SHALL wrap modulo 2**DEPTH_LOG2; full = (count = 2**DEPTH_LOG2), empty = (count = 0).
REQ-026 Repeat filter, when compiled in (REQ-032): a make event (bit9=0) whose {arrow, scancode} equals the stored last-make key SHALL be discarded silently, without affecting ovf or count.
REQ-027 Last-make key update: an accepted make stores its {arrow, scancode} and sets last_valid; a break (bit9=1) with matching {arrow, scancode} clears last_valid; breaks are never filtered.
REQ-028 If ovf_clr=1 and an overflow occurs in the same cycle, ovf SHALL end the cycle at 1 (set wins).

Reset
REQ-029 While rst=0: count=0, read/write pointers=0, a_valid=b_valid=0, ovf=0, last_valid=0; FIFO storage need not be cleared.
REQ-030 Reset assertion mid-transfer SHALL discard all queued events immediately (asynchronously).
REQ-031 After rst deasserts, the first rising clk edge with kv_valid=1 SHALL be accepted normally.

Configuration
REQ-032 Macro KEY_REPEAT_FILTER_EN defined: REQ-026/REQ-027 are active and last-make registers exist; undefined: no filter logic is present and every kv_valid event is subject only to REQ-015/REQ-016.

Verification
REQ-033 Route: push 0x01D then 0x175, a_ready=b_ready=1 -> a_valid with a_data=0x01D in cycle N+1, then b_valid with b_data=0x175 next cycle; count returns to 0.
REQ-034 Blocking: push 0x175, 0x01C, b_ready=0, a_ready=1 for 10 cycles -> b_valid=1 holding 0x175, a_valid=0, count=2; release b_ready -> 0x175 then 0x01C delivered in order.
REQ-035 Overflow: both ready=0, push 9 distinct events -> count=8, ovf=1, 9th event absent on drain; ovf_clr pulse -> ovf=0.
REQ-036 Full with simultaneous push+pop: count=8, a_ready=1 at head, kv_valid with 0x023 -> count stays 8, ovf=0, 0x023 delivered last.
REQ-037 Filter (KEY_REPEAT_FILTER_EN): push 0x01D, 0x01D, 0x01D, 0x21D, 0x01D -> delivered sequence 0x01D, 0x21D, 0x01D; without macro, all 5 delivered.
REQ-038 Reset: 3 events queued, rst=0 for 1 cycle -> count=0, a_valid=b_valid=0, ovf=0 immediately; the next push is delivered normally.
